aes_encrypt_driver: RTL and testbench
=====================================

# aes_encrypt_driver

Sequencing controller and state register for AES-128 encryption, the forward-direction counterpart of the existing decryption controller. Accepts a 128-bit plaintext and a precomputed 1408-bit key schedule, then runs initial AddRoundKey, 9 full rounds and a final round. Sits behind the same Avalon register interface as the decryption path and produces a 128-bit ciphertext with a level done flag.

## Interface
- `AES_ENC_ROUNDS`, 10, total rounds; fixed for AES-128, used only to derive the loop bound (9).
- `Clk` in 1 — single clock, rising edge.
- `Reset` in 1 — asynchronous, active-high.
- `Start_h` in 1 — start-encryption level flag from the control register.
- `KeySchedule` in 1408 — round key r at [1407-128r -: 128]; round 0 (cipher key) at [1407:1280], round 10 at [127:0].
- `msg_in` in 128 — plaintext, byte 0 at [127:120], column c at [127-32c -: 32].
- `msg_out` out 128 — internal state register; ciphertext when `Done_h`=1.
- `Done_h` out 1 — high while the FSM is in DONE.

## Operation
- States: IDLE, LOAD, ARK_INIT, SUB_LOOP, SHIFT_LOOP, MIX_0..MIX_3 (MIX_0 only without macro), ARK_LOOP, SUB_END, SHIFT_END, ARK_END, DONE.
- IDLE: state register holds; `round`=0; Start_h=1 -> LOAD.
- LOAD: state <= msg_in. -> ARK_INIT.
- ARK_INIT: state <= state ^ round key 0; round <= 1. -> SUB_LOOP.
- SUB_LOOP: S-box on all 16 bytes. -> SHIFT_LOOP.
- SHIFT_LOOP: row r rotated left by r bytes. -> MIX_0.
- MIX_c (word-wise): column c replaced by MixColumns(column c); MIX_3 -> ARK_LOOP.
- ARK_LOOP: state ^= round key `round`; if round==9 -> SUB_END, else round <= round+1, -> SUB_LOOP.
- SUB_END -> SHIFT_END -> ARK_END (xor round key 10) -> DONE.
- DONE: state holds; Start_h=0 -> IDLE; Start_h held high stays in DONE (no retrigger).
- Start_h changes outside IDLE/DONE are ignored; msg_in sampled only in LOAD; KeySchedule must be stable from LOAD to ARK_END.
- `round` is 4 bits, never exceeds 9 in loop; reset to 0 in IDLE and DONE.

## Timing
- Reset (async, any state): State=IDLE, state register=0, round=0, `msg_out`=0, `Done_h`=0. Reset mid-encryption discards all progress.
- Edge 0 = edge sampling Start_h=1 in IDLE. Word-wise: DONE entered at edge 68 (1 LOAD + 1 ARK_INIT + 9×7 + 3). Single-cycle MixColumns: edge 41 (1+1+9×4+3).
- `Done_h` and `msg_out` are registered-state decodes; no combinational path from inputs to outputs.
- Back-to-back: Start_h low for ≥1 cycle in DONE, then high in IDLE, restarts; minimum IDLE dwell 1 cycle.

## Configuration
- `AES_ENC_WORDWISE_MC_EN` defined: one `aes_mix_column` instance, MIX_0..MIX_3 process one column per cycle, latency 68.
- Undefined: four `aes_mix_column` instances, single MIX_0 state updates all columns, latency 41. Ciphertext identical in both builds.

## Structure
- Package `aes_enc_pkg`: state enum type, 256-entry S-box constant, `sub_bytes` and `shift_rows` functions, round-key slice helper, loop-bound constant (9).
- Sub-module `aes_mix_column`: combinational 32-bit column MixColumns (xtime-based GF(2^8) ×2/×3).
- Top holds FSM, round counter, state register and next-state mux.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> msg_out 69c4e0d86a7b0430d8cdb78070b4c55a, Done_h rising exactly at edge 68 (41 without macro).
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Start_h held high 200 cycles -> single encryption, Done_h stays 1, msg_out stable; drop Start_h -> IDLE next edge, Done_h=0.
- Reset asserted at edge 30 mid-loop -> immediately State=IDLE, msg_out=0, Done_h=0; subsequent Start_h gives correct C.1 result.
- msg_in changed to all-ones at edge 5 -> ciphertext still matches C.1 (sampled in LOAD only).
- Two back-to-back encryptions (C.1 then B) with 1-cycle Start_h low gap -> both ciphertexts correct, round counter restarted at 1.

Source files
------------

// File: rtl/aes_enc_pkg.sv
// aes_enc_pkg: shared AES-128 encryption types, S-box table and byte-level round helpers.
package aes_enc_pkg;

    localparam int AES_ENC_ROUNDS = 10;
    localparam logic [3:0] LOOP_ROUNDS = 4'(AES_ENC_ROUNDS - 1);
    localparam logic [3:0] LAST_ROUND = 4'(AES_ENC_ROUNDS);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_ARK_INIT, S_SUB_LOOP, S_SHIFT_LOOP,
        S_MIX_0, S_MIX_1, S_MIX_2, S_MIX_3, S_ARK_LOOP,
        S_SUB_END, S_SHIFT_END, S_ARK_END, S_DONE
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // state bytes are column-major: byte 4c+r sits at row r, column c
    function automatic logic [127:0] sub_bytes(input logic [0:15][7:0] s);
        return {SBOX[s[0]],  SBOX[s[1]],  SBOX[s[2]],  SBOX[s[3]],
                SBOX[s[4]],  SBOX[s[5]],  SBOX[s[6]],  SBOX[s[7]],
                SBOX[s[8]],  SBOX[s[9]],  SBOX[s[10]], SBOX[s[11]],
                SBOX[s[12]], SBOX[s[13]], SBOX[s[14]], SBOX[s[15]]};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [0:15][7:0] s);
        return {s[0],  s[5],  s[10], s[15],
                s[4],  s[9],  s[14], s[3],
                s[8],  s[13], s[2],  s[7],
                s[12], s[1],  s[6],  s[11]};
    endfunction

    function automatic logic [127:0] round_key(input logic [0:10][127:0] ks, input logic [3:0] r);
        return ks[r];
    endfunction

endpackage

// File: rtl/aes_encrypt_driver_if.sv
// aes_encrypt_driver_if: control-register side signals of the AES-128 encryption controller.
interface aes_encrypt_driver_if;
    logic          Start_h;
    logic [1407:0] KeySchedule;
    logic [127:0]  msg_in;
    logic [127:0]  msg_out;
    logic          Done_h;

    modport master (output Start_h, KeySchedule, msg_in, input msg_out, Done_h);
    modport slave  (input Start_h, KeySchedule, msg_in, output msg_out, Done_h);
endinterface

// File: rtl/aes_mix_column.sv
// aes_mix_column: combinational MixColumns of one 32-bit state column over GF(2^8).
module aes_mix_column (
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign {w_a0, w_a1, w_a2, w_a3} = i_col;

    // x3 is formed as xtime(a) ^ a
    assign o_col = {xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
                    w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
                    w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
                    xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)};
endmodule

// File: rtl/aes_encrypt_driver.sv
// aes_encrypt_driver: AES-128 encryption sequencer and state register.
// AES_ENC_WORDWISE_MC_EN selects one shared MixColumns unit (one column per cycle) instead of four.
module aes_encrypt_driver
    import aes_enc_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    aes_encrypt_driver_if.slave bus
);
    state_t           r_fsm;
    logic [127:0]     r_state;
    logic [3:0]       r_round;
    logic             r_done;
    logic [0:3][31:0] w_cols;
    logic [0:3][31:0] w_mix;
    logic             w_mix_last;
    logic [3:0]       w_rk_idx;
    logic [127:0]     w_ark;

    assign w_cols = r_state;

`ifdef AES_ENC_WORDWISE_MC_EN
    logic [1:0]  w_col_sel;
    logic [31:0] w_mc_out;
    assign w_col_sel = r_fsm == S_MIX_1 ? 2'd1 : r_fsm == S_MIX_2 ? 2'd2 : r_fsm == S_MIX_3 ? 2'd3 : 2'd0;
    assign w_mix_last = r_fsm == S_MIX_3;
    aes_mix_column u_mc (.i_col(w_cols[w_col_sel]), .o_col(w_mc_out));
    always_comb begin
        w_mix = w_cols;
        w_mix[w_col_sel] = w_mc_out;
    end
`else
    assign w_mix_last = 1'b1;
    for (genvar c = 0; c < 4; c++) begin : g_mc
        aes_mix_column u_mc (.i_col(w_cols[c]), .o_col(w_mix[c]));
    end
`endif

    // one shared AddRoundKey path for the initial, loop and final rounds
    assign w_rk_idx = r_fsm == S_ARK_INIT ? 4'd0 : r_fsm == S_ARK_END ? LAST_ROUND : r_round;
    assign w_ark = r_state ^ round_key(bus.KeySchedule, w_rk_idx);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    r_round <= '0;
                    if (bus.Start_h) r_fsm <= S_LOAD;
                end
                S_LOAD: begin
                    r_state <= bus.msg_in;
                    r_fsm   <= S_ARK_INIT;
                end
                S_ARK_INIT: begin
                    r_state <= w_ark;
                    r_round <= 4'd1;
                    r_fsm   <= S_SUB_LOOP;
                end
                S_SUB_LOOP: begin
                    r_state <= sub_bytes(r_state);
                    r_fsm   <= S_SHIFT_LOOP;
                end
                S_SHIFT_LOOP: begin
                    r_state <= shift_rows(r_state);
                    r_fsm   <= S_MIX_0;
                end
                S_MIX_0, S_MIX_1, S_MIX_2, S_MIX_3: begin
                    r_state <= w_mix;
                    r_fsm   <= w_mix_last ? S_ARK_LOOP : state_t'(r_fsm + 4'd1);
                end
                S_ARK_LOOP: begin
                    r_state <= w_ark;
                    if (r_round == LOOP_ROUNDS) r_fsm <= S_SUB_END;
                    else begin
                        r_round <= r_round + 4'd1;
                        r_fsm   <= S_SUB_LOOP;
                    end
                end
                S_SUB_END: begin
                    r_state <= sub_bytes(r_state);
                    r_fsm   <= S_SHIFT_END;
                end
                S_SHIFT_END: begin
                    r_state <= shift_rows(r_state);
                    r_fsm   <= S_ARK_END;
                end
                S_ARK_END: begin
                    r_state <= w_ark;
                    r_done  <= 1'b1;
                    r_fsm   <= S_DONE;
                end
                S_DONE: begin
                    r_round <= '0;
                    if (!bus.Start_h) begin
                        r_done <= 1'b0;
                        r_fsm  <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign bus.msg_out = r_state;
    assign bus.Done_h  = r_done;
endmodule

// File: tb/tb_aes_encrypt_driver.sv
// tb_aes_encrypt_driver: directed FIPS-197 vectors plus hold, mid-run reset and late msg_in sequences.
module tb_aes_encrypt_driver;
`ifdef AES_ENC_WORDWISE_MC_EN
    localparam int LAT = 68;
`else
    localparam int LAT = 41;
`endif

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        string        nm;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] sb [256];
    vec_t vecs [3];

    aes_encrypt_driver_if bus ();
    aes_encrypt_driver dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box derived from GF(2^8) inverse and the affine map, independent of any table
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] key_expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] ks;
        for (int i = 0; i < 44; i++) begin
            if (i < 4) w[i] = key[127 - 32*i -: 32];
            else begin
                t = w[i-1];
                if (i % 4 == 0) begin
                    t = {t[23:0], t[31:24]};
                    t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end
                w[i] = w[i-4] ^ t;
            end
            ks[1407 - 32*i -: 32] = w[i];
        end
        return ks;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [127:0] key, input logic [127:0] pt);
        bus.KeySchedule = key_expand(key);
        bus.msg_in = pt;
        @(negedge Clk);
        bus.Start_h = 1'b1;
    endtask

    task automatic wait_done(output int e);
        int n = 0;
        e = -1;
        while (e < 0 && n <= LAT + 4) begin
            @(posedge Clk);
            #1;
            if (bus.Done_h === 1'b1) e = n;
            n++;
        end
    endtask

    task automatic stop_run(input string nm);
        @(negedge Clk);
        bus.Start_h = 1'b0;
        @(posedge Clk);
        #1;
        chk({nm, "_clr"}, 128'(bus.Done_h), 128'd0);
    endtask

    task automatic run_enc(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct, input string nm);
        int e;
        load(key, pt);
        wait_done(e);
        chk({nm, "_lat"}, 128'(e), 128'(LAT));
        chk({nm, "_ct"}, bus.msg_out, ct);
        stop_run(nm);
    endtask

    initial begin
        int e;
        int bad;
        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, "c1"};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, "fipsb"};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97, "ecb1"};
        Reset = 1'b1;
        bus.Start_h = 1'b0;
        bus.msg_in = '0;
        bus.KeySchedule = '0;
        build_sbox();
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_msg_out", bus.msg_out, 128'd0);
        chk("rst_done", 128'(bus.Done_h), 128'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // back-to-back runs with a single low cycle of Start_h between them
        for (int i = 0; i < 3; i++) run_enc(vecs[i].key, vecs[i].pt, vecs[i].ct, vecs[i].nm);

        load(vecs[0].key, vecs[0].pt);
        wait_done(e);
        chk("hold_lat", 128'(e), 128'(LAT));
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge Clk);
            #1;
            if (bus.Done_h !== 1'b1 || bus.msg_out !== vecs[0].ct) bad++;
        end
        chk("hold_stable", 128'(bad), 128'd0);
        stop_run("hold");
        chk("idle_keeps_ct", bus.msg_out, vecs[0].ct);

        load(vecs[0].key, vecs[0].pt);
        repeat (31) @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        chk("midrst_msg_out", bus.msg_out, 128'd0);
        chk("midrst_done", 128'(bus.Done_h), 128'd0);
        @(negedge Clk);
        bus.Start_h = 1'b0;
        Reset = 1'b0;
        @(posedge Clk);
        run_enc(vecs[0].key, vecs[0].pt, vecs[0].ct, "after_rst");

        load(vecs[0].key, vecs[0].pt);
        repeat (6) @(posedge Clk);
        #1 bus.msg_in = '1;
        wait_done(e);
        chk("late_msg_lat", 128'(e), 128'(LAT - 6));
        chk("late_msg_ct", bus.msg_out, vecs[0].ct);
        stop_run("late_msg");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
